// File: rtl/dac_interface_pkg.sv
// Shared definitions for the TX DAC front end: settings-bus addresses,
// ramp FSM states and the DUC-to-DAC mux helper.
package dac_interface_pkg;

    // Settings-bus register map for the TX DAC path
    localparam logic [6:0] FR_TX_MUX       = 7'd40;
    localparam logic [6:0] FR_DAC_OFFSET_0 = 7'd41;
    localparam logic [6:0] FR_DAC_OFFSET_1 = 7'd42;
    localparam logic [6:0] FR_DAC_OFFSET_2 = 7'd43;
    localparam logic [6:0] FR_DAC_OFFSET_3 = 7'd44;
    localparam logic [6:0] FR_TX_CLIP_CLR  = 7'd45;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    // samples order: 0 = duc0_i, 1 = duc0_q, 2 = duc1_i, 3 = duc1_q.
    // Any select with bit 3 or bit 2 set yields zero (bit 3 = force zero,
    // 4..7 reserved).
    function automatic logic [15:0] select_sample(input logic [3:0]       sel,
                                                  input logic [3:0][15:0] samples);
        if (sel[3] || sel[2]) begin
            return 16'd0;
        end
        return samples[sel[1:0]];
    endfunction

endpackage

// File: rtl/dac_interface_if.sv
// Serial settings bus: the host side drives it, the DAC front end listens.
interface dac_interface_if;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;

    modport master (output serial_addr, output serial_data, output serial_strobe);
    modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/dac_chain.sv
// One DAC path after the mux: gain multiply (S3), offset add with
// saturation and truncation to the DAC width (S4), and a sticky clip counter.
module dac_chain #(
    parameter int DAC_WIDTH = 14,
    parameter int RAMP_BITS = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [15:0]          sample,
    input  logic        [RAMP_BITS:0]   gain,
    input  logic signed [15:0]          offset,
    input  logic                        clip_clear,
    output logic signed [DAC_WIDTH-1:0] dac_out,
    output logic        [15:0]          clip_count
);

    localparam int PROD_W = RAMP_BITS + 18;

    logic signed [PROD_W-1:0]    sample_ext;
    logic signed [PROD_W-1:0]    gain_ext;
    logic signed [PROD_W-1:0]    product;
    logic signed [15:0]          scaled_reg;
    logic signed [16:0]          sum;
    logic signed [15:0]          sat_val;
    logic                        clip_event;
    logic signed [DAC_WIDTH-1:0] dac_out_reg;
    logic        [15:0]          clip_count_reg;

    // Gain is unsigned, so it is zero-extended before the signed multiply
    assign sample_ext = PROD_W'(sample);
    assign gain_ext   = $signed(PROD_W'({1'b0, gain}));
    assign product    = sample_ext * gain_ext;

    // S3: scale by gain / 2^RAMP_BITS; full-scale gain is an exact pass-through
    always_ff @(posedge clock) begin
        if (reset) begin
            scaled_reg <= '0;
        end else begin
            scaled_reg <= 16'(product >>> RAMP_BITS);
        end
    end

    // Offset add in 17 bits, then clamp to the 16-bit signed range
    always_comb begin
        sum        = 17'(scaled_reg) + 17'(offset);
        sat_val    = sum[15:0];
        clip_event = 1'b0;
        if (sum[16:15] == 2'b01) begin
            sat_val    = 16'sh7FFF;
            clip_event = 1'b1;
        end else if (sum[16:15] == 2'b10) begin
            sat_val    = -16'sh8000;
            clip_event = 1'b1;
        end
    end

    // S4: keep the top DAC_WIDTH bits, truncating the rest
    always_ff @(posedge clock) begin
        if (reset) begin
            dac_out_reg <= '0;
        end else begin
            dac_out_reg <= DAC_WIDTH'(sat_val >>> (16 - DAC_WIDTH));
        end
    end

    // Clip counter: clear beats a coincident clip, and it sticks at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            clip_count_reg <= '0;
        end else if (clip_clear) begin
            clip_count_reg <= '0;
        end else if (clip_event && (clip_count_reg != 16'hFFFF)) begin
            clip_count_reg <= clip_count_reg + 16'd1;
        end
    end

    assign dac_out    = dac_out_reg;
    assign clip_count = clip_count_reg;

endmodule

// File: rtl/dac_interface.sv
// TX DAC front end: registers the DUC samples, routes them through the
// settings-programmed mux, and feeds four dac_chain paths that share one
// soft on/off gain ramp.
module dac_interface
    import dac_interface_pkg::*;
#(
    parameter int DAC_WIDTH = 14,
    parameter int RAMP_BITS = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    dac_interface_if.slave              settings,
    input  logic signed [15:0]          duc0_i,
    input  logic signed [15:0]          duc0_q,
    input  logic signed [15:0]          duc1_i,
    input  logic signed [15:0]          duc1_q,
    output logic signed [DAC_WIDTH-1:0] tx_a_a,
    output logic signed [DAC_WIDTH-1:0] tx_b_a,
    output logic signed [DAC_WIDTH-1:0] tx_a_b,
    output logic signed [DAC_WIDTH-1:0] tx_b_b,
    output logic        [15:0]          clip_0,
    output logic        [15:0]          clip_1,
    output logic        [15:0]          clip_2,
    output logic        [15:0]          clip_3,
    output logic        [3:0]           tx_numchan,
    output logic                        tx_active
);

    localparam logic [RAMP_BITS:0] GAIN_FULL = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [RAMP_BITS:0] GAIN_ONE  = {{RAMP_BITS{1'b0}}, 1'b1};

    logic [19:0]          mux_reg;
    logic [3:0][15:0]     duc_s1_reg;
    logic [DAC_WIDTH-1:0] dac_codes [4];
    logic [15:0]          clip_counts [4];
    ramp_state_t          state_reg, state_next;
    logic [RAMP_BITS:0]   gain_reg, gain_next;
    logic                 unused_data_bits;

    // Only the low 20 data bits carry settings for this block
    assign unused_data_bits = ^settings.serial_data[31:20];

    // Mux / channel-count register
    always_ff @(posedge clock) begin
        if (reset) begin
            mux_reg <= '0;
        end else if (settings.serial_strobe && (settings.serial_addr == FR_TX_MUX)) begin
            mux_reg <= settings.serial_data[19:0];
        end
    end

    // S1: capture the DUC samples
    always_ff @(posedge clock) begin
        if (reset) begin
            duc_s1_reg <= '0;
        end else begin
            duc_s1_reg <= {duc1_q, duc1_i, duc0_q, duc0_i};
        end
    end

    // Ramp FSM state and gain registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            gain_reg  <= '0;
        end else begin
            state_reg <= state_next;
            gain_reg  <= gain_next;
        end
    end

    // Ramp FSM: a direction change keeps the current gain and resumes from it
    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        case (state_reg)
            IDLE: begin
                gain_next = '0;
                if (enable) state_next = RAMP_UP;
            end
            RAMP_UP: begin
                if (!enable) begin
                    state_next = RAMP_DOWN;
                end else if (gain_reg >= (GAIN_FULL - GAIN_ONE)) begin
                    state_next = ON;
                    gain_next  = GAIN_FULL;
                end else begin
                    gain_next = gain_reg + GAIN_ONE;
                end
            end
            ON: begin
                gain_next = GAIN_FULL;
                if (!enable) state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (enable) begin
                    state_next = RAMP_UP;
                end else if (gain_reg <= GAIN_ONE) begin
                    state_next = IDLE;
                    gain_next  = '0;
                end else begin
                    gain_next = gain_reg - GAIN_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                gain_next  = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_path
            logic signed [15:0] offset_reg;
            logic signed [15:0] sample_s2_reg;
            logic               clip_clear;

            assign clip_clear = settings.serial_strobe
                             && (settings.serial_addr == FR_TX_CLIP_CLR)
                             && settings.serial_data[gi];

            // Per-DAC signed offset register
            always_ff @(posedge clock) begin
                if (reset) begin
                    offset_reg <= '0;
                end else if (settings.serial_strobe
                          && (settings.serial_addr == (FR_DAC_OFFSET_0 + 7'(gi)))) begin
                    offset_reg <= settings.serial_data[15:0];
                end
            end

            // S2: mux selection; a select change switches here without smoothing
            always_ff @(posedge clock) begin
                if (reset) begin
                    sample_s2_reg <= '0;
                end else begin
                    sample_s2_reg <= select_sample(mux_reg[4*gi +: 4], duc_s1_reg);
                end
            end

            dac_chain #(
                .DAC_WIDTH (DAC_WIDTH),
                .RAMP_BITS (RAMP_BITS)
            ) u_chain (
                .clock      (clock),
                .reset      (reset),
                .sample     (sample_s2_reg),
                .gain       (gain_reg),
                .offset     (offset_reg),
                .clip_clear (clip_clear),
                .dac_out    (dac_codes[gi]),
                .clip_count (clip_counts[gi])
            );
        end
    endgenerate

    assign tx_a_a     = $signed(dac_codes[0]);
    assign tx_b_a     = $signed(dac_codes[1]);
    assign tx_a_b     = $signed(dac_codes[2]);
    assign tx_b_b     = $signed(dac_codes[3]);
    assign clip_0     = clip_counts[0];
    assign clip_1     = clip_counts[1];
    assign clip_2     = clip_counts[2];
    assign clip_3     = clip_counts[3];
    assign tx_numchan = mux_reg[19:16];
    assign tx_active  = (state_reg != IDLE);

endmodule

// File: tb/tb_dac_interface.sv
// Directed bench for dac_interface: ramp timing, mux routing, offset,
// saturation, clip counters and synchronous reset.
module tb_dac_interface;
    import dac_interface_pkg::*;

    logic               clock;
    logic               reset;
    logic               enable;
    logic signed [15:0] duc0_i, duc0_q, duc1_i, duc1_q;
    logic signed [13:0] tx_a_a, tx_b_a, tx_a_b, tx_b_b;
    logic        [15:0] clip_0, clip_1, clip_2, clip_3;
    logic        [3:0]  tx_numchan;
    logic               tx_active;

    int n_checks = 0;
    int n_fail   = 0;

    dac_interface_if bus ();

    dac_interface #(
        .DAC_WIDTH (14),
        .RAMP_BITS (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .settings   (bus),
        .duc0_i     (duc0_i),
        .duc0_q     (duc0_q),
        .duc1_i     (duc1_i),
        .duc1_q     (duc1_q),
        .tx_a_a     (tx_a_a),
        .tx_b_a     (tx_b_a),
        .tx_a_b     (tx_a_b),
        .tx_b_b     (tx_b_b),
        .clip_0     (clip_0),
        .clip_1     (clip_1),
        .clip_2     (clip_2),
        .clip_3     (clip_3),
        .tx_numchan (tx_numchan),
        .tx_active  (tx_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_dac(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        check(tag, {18'd0, obs}, {18'd0, exp});
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
        bus.serial_addr   = a;
        bus.serial_data   = d;
        bus.serial_strobe = 1'b1;
        tick(1);
        bus.serial_strobe = 1'b0;
        $display("write addr %0d data %h", a, d);
    endtask

    initial begin
        reset             = 1'b1;
        enable            = 1'b0;
        duc0_i            = 16'sh1000;
        duc0_q            = 16'sh0800;
        duc1_i            = -16'sh1000;
        duc1_q            = 16'sh0004;
        bus.serial_addr   = '0;
        bus.serial_data   = '0;
        bus.serial_strobe = 1'b0;
        tick(3);

        // 1: reset state, then idle with enable low
        check_dac("rst_a_a", tx_a_a, 14'h0000);
        check("rst_active", {31'd0, tx_active}, 32'd0);
        check("rst_clip0", {16'd0, clip_0}, 32'd0);
        reset = 1'b0;
        tick(10);
        check_dac("idle_a_a", tx_a_a, 14'h0000);
        check_dac("idle_b_b", tx_b_b, 14'h0000);
        check("idle_active", {31'd0, tx_active}, 32'd0);
        check("idle_numchan", {28'd0, tx_numchan}, 32'd0);
        check("idle_clip3", {16'd0, clip_3}, 32'd0);

        // 2: ramp up with mux 0x3210
        write_reg(FR_TX_MUX, 32'h0000_3210);
        tick(5);
        enable = 1'b1;
        check("pre_active", {31'd0, tx_active}, 32'd0);
        tick(1);                                   // E0: enter RAMP_UP at gain 0
        check("up_active", {31'd0, tx_active}, 32'd1);
        tick(129);                                 // output reflects gain 127
        check_dac("gain127", tx_a_a, 14'h01FC);
        tick(1);                                   // gain 128
        check_dac("gain128", tx_a_a, 14'h0200);
        tick(127);                                 // gain 255
        check_dac("gain255", tx_a_a, 14'h03FC);
        tick(1);                                   // gain 256
        check_dac("gain256", tx_a_a, 14'h0400);
        tick(10);
        check_dac("on_a_a", tx_a_a, 14'h0400);
        check_dac("on_b_a", tx_b_a, 14'h0200);
        check_dac("on_a_b", tx_a_b, 14'h3C00);
        check_dac("on_b_b", tx_b_b, 14'h0001);

        // 3: full ramp down, then interrupt a ramp up at gain 100
        enable = 1'b0;
        tick(300);
        check("down_active", {31'd0, tx_active}, 32'd0);
        check_dac("down_a_a", tx_a_a, 14'h0000);
        enable = 1'b1;
        tick(1);                                   // E0
        tick(100);                                 // gain 100
        enable = 1'b0;
        tick(1);                                   // E101: RAMP_DOWN holding 100
        check("rd_active", {31'd0, tx_active}, 32'd1);
        tick(2);                                   // output from gain 100
        check_dac("rd_gain100", tx_a_a, 14'h0190);
        tick(1);                                   // output from gain 99
        check_dac("rd_gain99", tx_a_a, 14'h018C);
        tick(96);                                  // E200: gain 1
        check("rd_last", {31'd0, tx_active}, 32'd1);
        tick(1);                                   // E201: IDLE
        check("rd_idle", {31'd0, tx_active}, 32'd0);
        tick(1);
        check_dac("rd_gain1", tx_a_a, 14'h0004);
        tick(1);
        check_dac("rd_gain0", tx_a_a, 14'h0000);

        // 4: saturation in both directions and clip counting/clear
        enable = 1'b1;
        tick(270);
        write_reg(FR_DAC_OFFSET_0, 32'h0000_7000);
        write_reg(FR_DAC_OFFSET_1, 32'h0000_8000);
        duc0_i = 16'sh2000;
        duc0_q = -16'sh1000;
        tick(6);
        check_dac("sat_pos", tx_a_a, 14'h1FFF);
        check_dac("sat_neg", tx_b_a, 14'h2000);
        check("noclip2", {16'd0, clip_2}, 32'd0);
        write_reg(FR_TX_CLIP_CLR, 32'h0000_0003);
        check("clr_clip0", {16'd0, clip_0}, 32'd0);
        check("clr_clip1", {16'd0, clip_1}, 32'd0);
        tick(1);
        check("cnt1_clip0", {16'd0, clip_0}, 32'd1);
        check("cnt1_clip1", {16'd0, clip_1}, 32'd1);
        tick(1);
        check("cnt2_clip0", {16'd0, clip_0}, 32'd2);
        check("cnt_clip2", {16'd0, clip_2}, 32'd0);

        // 5: offset on DAC3, then force DAC3 to zero and DAC2 to reserved select
        write_reg(FR_DAC_OFFSET_3, 32'h0000_1234);
        tick(2);
        check_dac("off3_data", tx_b_b, 14'h048E);
        write_reg(FR_TX_MUX, 32'h0004_8510);
        check("numchan4", {28'd0, tx_numchan}, 32'd4);
        tick(4);
        check_dac("force_zero", tx_b_b, 14'h048D);
        check_dac("reserved", tx_a_b, 14'h0000);
        check_dac("keep_a_a", tx_a_a, 14'h1FFF);

        // 6: synchronous reset while ON
        check("pre_rst_on", {31'd0, tx_active}, 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        tick(1);
        reset = 1'b0;
        check("srst_active", {31'd0, tx_active}, 32'd0);
        check_dac("srst_a_a", tx_a_a, 14'h0000);
        check_dac("srst_b_b", tx_b_b, 14'h0000);
        check("srst_clip0", {16'd0, clip_0}, 32'd0);
        check("srst_numchan", {28'd0, tx_numchan}, 32'd0);
        tick(6);
        check_dac("post_a_a", tx_a_a, 14'h0000);
        check_dac("post_b_b", tx_b_b, 14'h0000);
        check("post_active", {31'd0, tx_active}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_interface.md
Name: dac_interface

Overview:
TX-side counterpart of the ADC front end. It takes I/Q samples from the two DUC channels and routes them to the four DAC outputs through a settings-programmed mux. Each DAC path then gets a soft on/off gain ramp, a programmable DC offset, and saturation with clip counters. It sits between the TX DUC chain and the AD9862 DAC pins, and is configured over the serial settings bus.

Parameters:
DAC_WIDTH, 14, DAC output word width; the top bits of the 16-bit corrected sample.
RAMP_BITS, 8, gain ramp resolution; full-scale gain is 2^RAMP_BITS, so a full ramp takes 2^RAMP_BITS cycles.

Ports:
clock  in  1  system clock, the only clock
reset  in  1  synchronous, active-high reset
enable  in  1  TX enable; drives the ramp FSM
serial_addr  in  7  settings bus address
serial_data  in  32  settings bus data
serial_strobe  in  1  settings bus write strobe
duc0_i, duc0_q, duc1_i, duc1_q  in  16 each  signed DUC samples, one per clock
tx_a_a, tx_b_a, tx_a_b, tx_b_b  out  DAC_WIDTH each  signed DAC codes for DAC0..3
clip_0, clip_1, clip_2, clip_3  out  16 each  per-DAC saturation event counts
tx_numchan  out  4  active TX channel count from the mux register
tx_active  out  1  high whenever the ramp FSM is not in IDLE

Behaviour:
- Reset (synchronous, active-high):
  - All DAC outputs, clip counters and tx_numchan are 0.
  - FSM is in IDLE with gain 0.
  - All settings registers are 0, so every DAC selects duc0_i and every offset is 0.
  - All pipeline registers are cleared.
- FR_TX_MUX register:
  - [3:0] DAC0 select, [7:4] DAC1, [11:8] DAC2, [15:12] DAC3.
  - Select values: 0 = duc0_i, 1 = duc0_q, 2 = duc1_i, 3 = duc1_q.
  - Select bit3 set forces zero; values 4..7 are reserved and also give zero.
  - [19:16] drives tx_numchan.
- FR_DAC_OFFSET_n: [15:0] is a signed offset for DAC n.
- FR_TX_CLIP_CLR: a write clears clip_n for every set data bit [3:0].
  - The clear applies in the cycle after the strobe.
  - If a clip event and a clear land in the same cycle, the clear wins.
- Pipeline, fixed latency of 4 clocks from DUC input to DAC pin:
  - S1: register the DUC inputs.
  - S2: mux selection.
  - S3: sample × gain, as 16-bit signed × (RAMP_BITS+1)-bit unsigned, arithmetic shift right by RAMP_BITS, keep 16 bits. Gain 256 is exact pass-through.
  - S4: add the 16-bit offset in 17 bits, saturate to [-32768, 32767], output bits [15:16-DAC_WIDTH] (truncate, no rounding).
- Clip counting: a clip event is S4 saturation in either direction.
  - clip_n increments once per clipped sample.
  - It holds at 0xFFFF and does not wrap.
- Ramp FSM, states IDLE, RAMP_UP, ON, RAMP_DOWN:
  - IDLE: gain = 0. enable=1 goes to RAMP_UP.
  - RAMP_UP: gain +1 per clock. Reaching 2^RAMP_BITS goes to ON. enable=0 goes to RAMP_DOWN, continuing from the current gain.
  - ON: gain = 2^RAMP_BITS. enable=0 goes to RAMP_DOWN.
  - RAMP_DOWN: gain −1 per clock. Reaching 0 goes to IDLE. enable=1 goes to RAMP_UP, continuing from the current gain.
- Gain is applied at S3 in the same cycle it is registered.
  - In IDLE the DAC output is sat(offset), not 0, so the offset is always present.
- Settings writes take effect one clock after the strobe and are never blocked by the FSM state.
- A mux change mid-stream switches at the S2 boundary; no glitch suppression is applied.

Decomposition:
- Add FR_TX_MUX, FR_DAC_OFFSET_0..3 and FR_TX_CLIP_CLR to the shared standard register include.
- Reuse the existing setting_reg for FR_TX_MUX and the four offset registers.
- New sub-module dac_chain, instantiated four times: gain multiply, offset add, saturate, truncate and clip counter for one DAC.
- The ramp FSM and mux stay in the top level.

Test Plan:
1. Reset, then idle with enable=0: all tx_* = 0, clip_* = 0, tx_active = 0.
2. Mux = 0x3210, enable=1, duc0_i = 0x1000: tx_active rises the next cycle; after 256 ramp cycles plus 4 latency, tx_a_a = 0x0400 steady. Ramp midpoint (gain 128) gives 0x0200.
3. enable drops at gain 100: gain decrements to 0 in 100 cycles; tx_active falls when IDLE is entered and the output returns to 0.
4. Offset_0 = 0x7000, duc0_i = 0x2000, gain full: tx_a_a = 0x1FFF; clip_0 counts +1 per clock; a CLIP_CLR write with bit0 set zeroes it the next cycle.
5. Mux nibble for DAC3 = 0x8: tx_b_b = sat(offset_3) >> 2 regardless of input; a mux write of [19:16] = 4 gives tx_numchan = 4.
6. Synchronous reset asserted in ON state: the next cycle has gain 0, IDLE, registers cleared and outputs 0.
